// File: rtl/dcache_wt.sv
`default_nettype none
// ============================================================================
// Module   : dcache_wt
// Purpose  : Direct-mapped, write-through, no-write-allocate data cache with
//            one 32-bit word per line. Read hits return data combinationally
//            in the request cycle. Read misses and all stores are forwarded
//            to a word-wide backing memory over a req/ack handshake and
//            stall the CPU until the memory acknowledges. Read hit and read
//            miss counts are kept in two wrapping 16-bit counters.
// Ports    : clk_i, rst_i            - clock, synchronous active-high reset
//            cpu_addr_i/cpu_wdata_i  - CPU byte address and store data
//            cpu_MemRead_i/_MemWrite_i - level-held load/store requests
//            cpu_rdata_o, stall_o    - load data and CPU freeze
//            mem_req_o/_we_o/_addr_o/_wdata_o - registered memory request
//            mem_ack_i, mem_rdata_i  - one-cycle ack with fill data
//            rd_hit_cnt_o, rd_miss_cnt_o - read performance counters
// Revision : 1.0 - initial release
// ============================================================================
module dcache_wt #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    input  logic        cpu_MemRead_i,
    input  logic        cpu_MemWrite_i,
    output logic [31:0] cpu_rdata_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [15:0] rd_hit_cnt_o,
    output logic [15:0] rd_miss_cnt_o
);

    localparam int          C_LINES      = 1 << INDEX_BITS;
    localparam int          C_TAG_BITS   = 30 - INDEX_BITS;
    localparam logic [31:0] C_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_WAIT = 2'd2,
        S_WR_DONE = 2'd3
    } state_t;

    state_t                      r_state;
    logic [C_LINES-1:0]          r_valid;
    logic [C_TAG_BITS-1:0]       r_tag  [C_LINES];
    logic [31:0]                 r_data [C_LINES];
    logic                        r_mem_req;
    logic                        r_mem_we;
    logic [31:0]                 r_mem_addr;
    logic [31:0]                 r_mem_wdata;
    logic [15:0]                 r_hit_cnt;
    logic [15:0]                 r_miss_cnt;
    // Set by a fill so the IDLE re-evaluation hit that follows is not counted.
    logic                        r_fill_done;

    // CPU-side lookup
    logic [INDEX_BITS-1:0]       w_index;
    logic [C_TAG_BITS-1:0]       w_tag;
    logic                        w_hit;
    logic                        w_is_write;
    logic                        w_is_read;

    // Lookup of the outstanding request, taken from the registered address
    // so fills and write-through updates do not depend on the CPU holding
    // its address stable.
    logic [INDEX_BITS-1:0]       w_p_index;
    logic [C_TAG_BITS-1:0]       w_p_tag;
    logic                        w_p_hit;
    logic                        w_fill;
    logic                        w_wr_update;

    logic                        w_stall;
    logic [31:0]                 w_rdata;

    assign w_index    = cpu_addr_i[INDEX_BITS+1:2];
    assign w_tag      = cpu_addr_i[31:INDEX_BITS+2];
    assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
    // A simultaneous read and write request is handled as a write.
    assign w_is_write = cpu_MemWrite_i;
    assign w_is_read  = cpu_MemRead_i && !cpu_MemWrite_i;

    assign w_p_index   = r_mem_addr[INDEX_BITS+1:2];
    assign w_p_tag     = r_mem_addr[31:INDEX_BITS+2];
    assign w_p_hit     = r_valid[w_p_index] && (r_tag[w_p_index] == w_p_tag);
    assign w_fill      = (r_state == S_RD_WAIT) && mem_ack_i;
    assign w_wr_update = (r_state == S_WR_WAIT) && mem_ack_i && w_p_hit;

    // ------------------------------------------------------------------
    // Combinational CPU-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_stall = 1'b0;
        w_rdata = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_is_write) begin
                    w_stall = 1'b1;
                end else if (w_is_read) begin
                    if (w_hit) begin
                        w_rdata = r_data[w_index];
                    end else begin
                        w_stall = 1'b1;
                    end
                end
            end
            S_RD_WAIT,
            S_WR_WAIT: w_stall = 1'b1;
            default:   w_stall = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM, valid bits, memory request registers and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_hit_cnt   <= 16'h0;
            r_miss_cnt  <= 16'h0;
            r_fill_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_fill_done <= 1'b0;
                    if (w_is_write) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= cpu_addr_i & C_ALIGN_MASK;
                        r_mem_wdata <= cpu_wdata_i;
                        r_state     <= S_WR_WAIT;
                    end else if (w_is_read) begin
                        if (w_hit) begin
                            if (!r_fill_done) begin
                                r_hit_cnt <= r_hit_cnt + 16'd1;
                            end
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= cpu_addr_i & C_ALIGN_MASK;
                            r_miss_cnt <= r_miss_cnt + 16'd1;
                            r_state    <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (mem_ack_i) begin
                        // A fill replaces whatever line sat at this index.
                        r_valid[w_p_index] <= 1'b1;
                        r_mem_req          <= 1'b0;
                        r_fill_done        <= 1'b1;
                        r_state            <= S_IDLE;
                    end
                end
                S_WR_WAIT: begin
                    if (mem_ack_i) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_WR_DONE;
                    end
                end
                default: begin
                    // Store retires this cycle; the held request is ignored.
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Tag and data storage carry no reset; the valid bits guard them.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (w_fill) begin
                r_tag[w_p_index]  <= w_p_tag;
                r_data[w_p_index] <= mem_rdata_i;
            end else if (w_wr_update) begin
                r_data[w_p_index] <= r_mem_wdata;
            end
        end
    end

    assign cpu_rdata_o   = w_rdata;
    assign stall_o       = w_stall;
    assign mem_req_o     = r_mem_req;
    assign mem_we_o      = r_mem_we;
    assign mem_addr_o    = r_mem_addr;
    assign mem_wdata_o   = r_mem_wdata;
    assign rd_hit_cnt_o  = r_hit_cnt;
    assign rd_miss_cnt_o = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dcache_wt.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_wt
// Purpose  : Self-checking bench for dcache_wt. Directed scenarios followed
//            by random loads/stores, all compared against a behavioural
//            cache + backing-memory model held in plain arrays.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_wt;

    localparam int IB    = 4;
    localparam int LINES = 16;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    dcache_wt #(.INDEX_BITS(IB)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cpu_addr_i    (cpu_addr),
        .cpu_wdata_i   (cpu_wdata),
        .cpu_MemRead_i (cpu_rd),
        .cpu_MemWrite_i(cpu_wr),
        .cpu_rdata_o   (cpu_rdata),
        .stall_o       (stall),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata),
        .rd_hit_cnt_o  (hit_cnt),
        .rd_miss_cnt_o (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: cache contents, backing memory, counters.
    bit          m_valid [LINES];
    logic [31:0] m_tag   [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] bmem    [int unsigned];
    int          m_hits;
    int          m_misses;

    int n_vec;
    int n_err;

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a >> 2) % LINES;
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> (IB + 2);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        int unsigned w;
        w = a >> 2;
        if (!bmem.exists(w)) bmem[w] = $urandom;
        return bmem[w];
    endfunction

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s observed=%h expected=%h", nm, fld, obs, exp);
        end
    endtask

    task automatic chk_counters(input string nm);
        chk(nm, "hit_cnt",  {16'h0, hit_cnt},  m_hits   & 32'hFFFF);
        chk(nm, "miss_cnt", {16'h0, miss_cnt}, m_misses & 32'hFFFF);
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Load of address a; a miss is acknowledged lat cycles after the request.
    task automatic do_read(input logic [31:0] a, input int lat, input string nm);
        logic [31:0] exp;
        @(negedge clk);
        cpu_addr = a;
        cpu_rd   = 1'b1;
        cpu_wr   = 1'b0;
        #1;
        chk_counters(nm);
        if (model_hit(a)) begin
            chk(nm, "stall_hit", {31'h0, stall}, 32'h0);
            chk(nm, "rdata_hit", cpu_rdata, m_data[idx_of(a)]);
            chk(nm, "req_hit",   {31'h0, mem_req}, 32'h0);
            m_hits++;
        end else begin
            chk(nm, "stall_c0", {31'h0, stall}, 32'h1);
            chk(nm, "rdata_c0", cpu_rdata, 32'h0);
            m_misses++;
            exp = mem_read(a);
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                if (c == lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = exp;
                end
                #1;
                chk(nm, "req",   {31'h0, mem_req}, 32'h1);
                chk(nm, "we",    {31'h0, mem_we},  32'h0);
                chk(nm, "addr",  mem_addr, a & 32'hFFFF_FFFC);
                chk(nm, "stall", {31'h0, stall},   32'h1);
            end
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            #1;
            chk(nm, "stall_fill", {31'h0, stall}, 32'h0);
            chk(nm, "rdata_fill", cpu_rdata, exp);
            chk(nm, "req_fill",   {31'h0, mem_req}, 32'h0);
            m_valid[idx_of(a)] = 1'b1;
            m_tag[idx_of(a)]   = tag_of(a);
            m_data[idx_of(a)]  = exp;
        end
        @(negedge clk);
        cpu_rd = 1'b0;
    endtask

    // Store of d to a, acknowledged lat cycles after the request.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input int lat, input bit both, input string nm);
        bit was_hit;
        @(negedge clk);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_wr    = 1'b1;
        cpu_rd    = both;
        #1;
        chk_counters(nm);
        chk(nm, "stall_c0", {31'h0, stall}, 32'h1);
        chk(nm, "rdata_c0", cpu_rdata, 32'h0);
        was_hit = model_hit(a);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == lat) mem_ack = 1'b1;
            #1;
            chk(nm, "req",   {31'h0, mem_req}, 32'h1);
            chk(nm, "we",    {31'h0, mem_we},  32'h1);
            chk(nm, "addr",  mem_addr, a & 32'hFFFF_FFFC);
            chk(nm, "wdata", mem_wdata, d);
            chk(nm, "stall", {31'h0, stall},   32'h1);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk(nm, "stall_done", {31'h0, stall},   32'h0);
        chk(nm, "req_done",   {31'h0, mem_req}, 32'h0);
        chk(nm, "rdata_done", cpu_rdata, 32'h0);
        if (was_hit) m_data[idx_of(a)] = d;
        bmem[a >> 2] = d;
        @(negedge clk);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    // Hold a load of a (already cached) for n consecutive cycles.
    task automatic hit_burst(input logic [31:0] a, input int n);
        @(negedge clk);
        cpu_addr = a;
        cpu_rd   = 1'b1;
        repeat (n) @(negedge clk);
        cpu_rd = 1'b0;
        m_hits += n;
        #1;
    endtask

    initial begin
        logic [31:0] ra;
        int          op;
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        model_reset();
        bmem[32'h100 >> 2] = 32'hDEADBEEF;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset", "req",   {31'h0, mem_req}, 32'h0);
        chk("reset", "we",    {31'h0, mem_we},  32'h0);
        chk("reset", "addr",  mem_addr,  32'h0);
        chk("reset", "wdata", mem_wdata, 32'h0);
        chk("reset", "stall", {31'h0, stall}, 32'h0);
        chk_counters("reset");

        // Cold read, hit, write-through, hit of new data
        do_read(32'h100, 3, "cold_rd");
        do_read(32'h100, 1, "rehit");
        do_write(32'h100, 32'h12345678, 2, 1'b0, "wr_hit");
        do_read(32'h100, 1, "rd_after_wr");

        // Store miss does not allocate; the resident line survives
        do_write(32'h140, 32'hCAFEF00D, 2, 1'b0, "wr_miss");
        do_read(32'h100, 1, "still_hit");
        do_read(32'h140, 2, "rd_noalloc");

        // Alias eviction on index 0
        do_read(32'h100, 1, "alias_a");
        do_read(32'h140, 4, "alias_b");
        do_read(32'h100, 2, "alias_a2");

        // Simultaneous read+write is a store
        do_write(32'h183, 32'hA5A5_5A5A, 1, 1'b1, "both");
        do_read(32'h180, 1, "both_rd");

        // Reset while waiting for a fill, late ack afterwards
        do_read(32'h1C0, 1, "pre_rst");
        @(negedge clk);
        cpu_addr = 32'h2C4;
        cpu_rd   = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mid", "req_wait", {31'h0, mem_req}, 32'h1);
        @(negedge clk);
        rst    = 1'b1;
        cpu_rd = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
        #1;
        model_reset();
        chk("rst_mid", "req",   {31'h0, mem_req}, 32'h0);
        chk("rst_mid", "stall", {31'h0, stall},   32'h0);
        chk_counters("rst_mid");
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("rst_mid", "req_late_ack", {31'h0, mem_req}, 32'h0);
        do_read(32'h2C4, 2, "post_rst");
        do_read(32'h1C0, 1, "post_rst_b");

        // Random loads and stores
        for (int i = 0; i < 150; i++) begin
            ra = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
               | $urandom_range(0, 3) | ($urandom_range(0, 1) << 20);
            op = $urandom_range(0, 9);
            if (op < 6)
                do_read(ra, $urandom_range(1, 4), "rnd_rd");
            else
                do_write(ra, $urandom, $urandom_range(1, 4), (op == 9), "rnd_wr");
        end

        // Hit counter wrap
        do_read(32'h100, 2, "wrap_prep");
        hit_burst(32'h100, 65535 - (m_hits % 65536));
        chk("wrap", "hit_ffff", {16'h0, hit_cnt}, 32'hFFFF);
        hit_burst(32'h100, 1);
        chk("wrap", "hit_zero", {16'h0, hit_cnt}, 32'h0);
        chk_counters("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
